// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared RAM port between icache refills and dcache block loads/writebacks.
// Dcache has priority, and a grant-streak limit guarantees that the icache still makes progress.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int BLOCK_WORDS  = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic                  i_done,
    output logic [31:0]           i_load,
    input  logic                  d_req,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_store,
    output logic                  d_ack,
    output logic                  d_done,
    output logic [31:0]           d_load,
    output logic                  ram_ren,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_store,
    input  logic [31:0]           ram_load,
    input  logic                  ram_ready
);
    localparam int BW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_WORDS - 1);
    localparam logic [SW-1:0] SMAX      = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, I_XFER, D_XFER} state_t;

    state_t          state;
    logic [BW-1:0]   beat_cnt;
    logic [SW-1:0]   d_streak;
    logic            grant_d;
    logic            grant_i;
    logic            last_beat;
    logic [ADDR_WIDTH-1:0] beat_offs;

    always_comb begin
        grant_d   = d_req & ~(i_req & (d_streak == SMAX));
        grant_i   = i_req & ~grant_d;
        last_beat = (beat_cnt == LAST_BEAT);
        beat_offs = ADDR_WIDTH'(beat_cnt) << 2;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            beat_cnt <= '0;
            d_streak <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state <= D_XFER;
                        // The streak only grows while the icache is actually waiting.
                        if (!i_req)
                            d_streak <= '0;
                        else if (d_streak != SMAX)
                            d_streak <= d_streak + 1'b1;
                    end else if (grant_i) begin
                        state    <= I_XFER;
                        d_streak <= '0;
                    end
                end
                default: begin
                    if (ram_ready) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // The beat handshake passes ram_ready straight through so that data is acked in the RAM's cycle.
    always_comb begin
        i_ack     = 1'b0;
        i_done    = 1'b0;
        i_load    = '0;
        d_ack     = 1'b0;
        d_done    = 1'b0;
        d_load    = '0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        case (state)
            I_XFER: begin
                ram_ren  = 1'b1;
                ram_addr = i_addr + beat_offs;
                i_ack    = ram_ready;
                i_done   = ram_ready & last_beat;
                i_load   = ram_ready ? ram_load : '0;
            end
            D_XFER: begin
                ram_wen   = d_wen;
                ram_ren   = ~d_wen;
                ram_addr  = d_addr + beat_offs;
                ram_store = d_store;
                d_ack     = ram_ready;
                d_done    = ram_ready & last_beat;
                d_load    = ram_ready ? ram_load : '0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter: expected beats are queued at request time
// and then checked against the RAM-side activity and the requester handshakes.
module tb_mem_bus_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        i_req, d_req, d_wen;
    logic [15:0] i_addr, d_addr;
    logic [31:0] d_store;
    logic        i_ack, i_done, d_ack, d_done;
    logic [31:0] i_load, d_load;
    logic        ram_ren, ram_wen;
    logic [15:0] ram_addr;
    logic [31:0] ram_store, ram_load;
    logic        ram_ready = 1'b0;

    typedef struct {
        bit          is_d;
        bit          wen;
        logic [15:0] addr;
        bit          done;
        logic [31:0] store;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    wait_n = 0;
    int    xfer_cycles = 0;

    mem_bus_arbiter #(.ADDR_WIDTH(16), .BLOCK_WORDS(2), .MAX_D_STREAK(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_done(i_done), .i_load(i_load),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
        .d_ack(d_ack), .d_done(d_done), .d_load(d_load),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    assign ram_load = mem_word(ram_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_block(input bit is_d, input bit wen, input logic [15:0] base,
                              input logic [31:0] store);
        for (int b = 0; b < 2; b++) begin
            beat_t e;
            e.is_d  = is_d;
            e.wen   = wen;
            e.addr  = base + 16'(4 * b);
            e.done  = (b == 1);
            e.store = store;
            sb.push_back(e);
        end
    endtask

    task automatic run(input int d_tgt, input int i_tgt, input int budget);
        int dn = 0;
        int in_ = 0;
        int cyc = 0;
        while ((dn < d_tgt || in_ < i_tgt) && cyc < budget) begin
            @(negedge CLK);
            cyc++;
            if (d_done) begin dn++; if (dn >= d_tgt) d_req = 1'b0; end
            if (i_done) begin in_++; if (in_ >= i_tgt) i_req = 1'b0; end
        end
        chk("run_complete", (dn >= d_tgt && in_ >= i_tgt), 1);
        d_req = 1'b0;
        i_req = 1'b0;
        @(negedge CLK);
    endtask

    // RAM responder: ready after wait_n stall cycles per beat.
    initial begin
        int stall = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (ram_ren || ram_wen) begin
                if (stall == wait_n) begin ram_ready = 1'b1; stall = 0; end
                else begin ram_ready = 1'b0; stall++; end
            end else begin
                ram_ready = 1'b0;
                stall = 0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (ram_ren || ram_wen) begin
                xfer_cycles++;
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL sb_nonempty observed=0 expected>0 addr=%0h", ram_addr);
                end
                if (sb.size() != 0) begin
                    beat_t e;
                    e = sb[0];
                    chk("ram_addr", ram_addr, e.addr);
                    chk("ram_wen", ram_wen, e.wen);
                    chk("ram_ren", ram_ren, !e.wen);
                    if (e.wen) chk("ram_store", ram_store, e.store);
                    chk("ack_owner", {i_ack, d_ack}, ram_ready ? (e.is_d ? 2'b01 : 2'b10) : 2'b00);
                    if (ram_ready) begin
                        chk("done", e.is_d ? d_done : i_done, e.done);
                        chk("nonowner_done", e.is_d ? i_done : d_done, 0);
                        chk("load", e.is_d ? d_load : i_load, mem_word(e.addr));
                        chk("nonowner_load", e.is_d ? i_load : d_load, 0);
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("idle_quiet", {i_ack, d_ack, i_done, d_done, i_load, d_load}, 0);
            end
        end
    end

    initial begin
        int k;
        nRST = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        i_addr = '0; d_addr = '0; d_store = '0;
        @(negedge CLK);
        chk("rst_ram_en", {ram_ren, ram_wen}, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_store", ram_store, 0);
        chk("rst_acks", {i_ack, i_done, d_ack, d_done}, 0);
        chk("rst_loads", {i_load, d_load}, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // Icache-only block read.
        push_block(0, 0, 16'h0100, '0);
        i_addr = 16'h0100; i_req = 1'b1;
        run(0, 1, 20);

        // Simultaneous requests: dcache writeback wins, then icache.
        push_block(1, 1, 16'h0200, 32'hCAFE_0200);
        push_block(0, 0, 16'h0180, '0);
        d_addr = 16'h0200; d_wen = 1'b1; d_store = 32'hCAFE_0200;
        i_addr = 16'h0180;
        d_req = 1'b1; i_req = 1'b1;
        run(1, 1, 30);

        // Streak limit: four dcache blocks, then icache, then dcache resumes.
        d_wen = 1'b0; d_addr = 16'h0800; i_addr = 16'h0900;
        for (int n = 0; n < 4; n++) push_block(1, 0, 16'h0800, '0);
        push_block(0, 0, 16'h0900, '0);
        push_block(1, 0, 16'h0800, '0);
        d_req = 1'b1; i_req = 1'b1;
        run(5, 1, 80);

        // Streak cleared: a fresh simultaneous request goes to dcache first.
        push_block(1, 0, 16'h0A00, '0);
        push_block(0, 0, 16'h0B00, '0);
        d_addr = 16'h0A00; i_addr = 16'h0B00;
        d_req = 1'b1; i_req = 1'b1;
        run(1, 1, 30);

        // Three wait states per beat.
        wait_n = 3;
        xfer_cycles = 0;
        push_block(0, 0, 16'h0400, '0);
        i_addr = 16'h0400; i_req = 1'b1;
        run(0, 1, 50);
        chk("stall_cycles", xfer_cycles, 8);
        wait_n = 0;

        // Address wrap at the top of the space.
        push_block(1, 0, 16'hFFFC, '0);
        d_addr = 16'hFFFC; d_wen = 1'b0; d_req = 1'b1;
        run(1, 0, 20);

        // Reset after the first beat abandons the block.
        push_block(0, 0, 16'h0300, '0);
        i_addr = 16'h0300; i_req = 1'b1;
        k = 0;
        while (i_ack !== 1'b1 && k < 20) begin @(negedge CLK); k++; end
        chk("first_beat_seen", i_ack, 1);
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("midrst_ram", {ram_ren, ram_wen, ram_addr, ram_store}, 0);
        chk("midrst_acks", {i_ack, i_done, d_ack, d_done}, 0);
        chk("midrst_load", i_load, 0);
        sb.delete();
        i_req = 1'b0;
        @(negedge CLK);
        chk("midrst_no_done", i_done, 0);
        nRST = 1'b1;
        @(negedge CLK);
        push_block(0, 0, 16'h0300, '0);
        i_req = 1'b1;
        run(0, 1, 20);

        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
